imem_fetch_ctrl: RTL
====================

Name: imem_fetch_ctrl

Overview:
- Sequences the 64 KiB instruction ROM.
- Owns the fetch PC and issues one-word reads to IMEM, which has 1-cycle registered read latency and drives zero when not read-enabled.
- Captures returned words into a 2-entry buffer.
- Presents instructions to decode over a valid/ready handshake and supports PC redirect (branch/jump/trap) with a flush of in-flight and buffered words.

Parameters:
- ADDR_DEPTH, 14, IMEM word-address width; must match IMEM.
- RESET_PC, 32'h0000_0000, byte PC fetched first after reset.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset; synchronous, active-high.
- FETCH_EN  in  1  1 = issue reads; 0 = stop issuing, buffered words still drain.
- REDIRECT  in  1  load REDIRECT_PC and flush.
- REDIRECT_PC  in  32  new byte PC; bits [1:0] ignored (treated as 0).
- IMEM_RDEN  out  1  to IMEM RDEN.
- IMEM_ADDR  out  ADDR_DEPTH  to IMEM ADDR; equals fetch_pc[ADDR_DEPTH+1:2].
- IMEM_DATA  in  32  from IMEM MEM_OUT.
- IR_VALID  out  1  buffer head holds a valid instruction.
- IR_READY  in  1  decode accepts head.
- IR  out  32  head instruction word.
- IR_PC  out  32  byte PC of head instruction.

Behaviour:
- State after RST:
  - fetch_pc = RESET_PC, count = 0, inflight = 0, state = IDLE.
  - IR_VALID = 0, IR = 0, IR_PC = 0, IMEM_RDEN = 0.
- FSM, 2 states:
  - IDLE -> RUN when FETCH_EN = 1.
  - RUN -> IDLE when FETCH_EN = 0.
  - No issue in IDLE. RST in any state returns to IDLE.
- Definitions:
  - pop = IR_VALID & IR_READY.
  - issue = (state == RUN) & FETCH_EN & ((count + inflight - pop) < 2), or REDIRECT & FETCH_EN.
  - IMEM_RDEN = issue. IMEM_RDEN and IMEM_ADDR are combinational from registered state plus REDIRECT / REDIRECT_PC / IR_READY.
- Read timing:
  - Read issued in cycle t makes IMEM_DATA valid in cycle t+1.
  - If not killed, the word is written to the buffer tail with its PC at the end of t+1.
  - IR_VALID is seen at t+2.
  - inflight <= issue each cycle.
- PC update:
  - On issue: fetch_pc <= fetch_pc + 4 (32-bit wrap).
  - IMEM_ADDR wraps naturally modulo 2^ADDR_DEPTH words.
- Buffer:
  - 2-entry FIFO, count 0..2. IR, IR_PC and IR_VALID come from the head register (no combinational path from IMEM_DATA).
  - Simultaneous pop and write keep count unchanged with correct order.
  - The issue rule guarantees no overflow; overflow is an assertion failure.
- Throughput:
  - With IR_READY held at 1 and FETCH_EN = 1, one instruction per cycle in steady state.
  - If IR_READY = 0, at most 2 buffered words plus 0 in flight; issue stops until a pop.
- REDIRECT in cycle t (highest priority):
  - Buffer cleared (count <= 0).
  - IMEM_DATA returning in cycle t is discarded.
  - A pop in cycle t is still a completed handshake for decode; the controller ignores it.
  - If FETCH_EN = 1: IMEM_ADDR = REDIRECT_PC[ADDR_DEPTH+1:2], IMEM_RDEN = 1, fetch_pc <= {REDIRECT_PC[31:2],2'b00} + 4, and inflight is marked live. First new IR_VALID appears at t+2 with IR_PC = aligned REDIRECT_PC.
  - If FETCH_EN = 0: fetch_pc <= aligned REDIRECT_PC, no issue.
- FETCH_EN falling:
  - An in-flight read still lands in the buffer.
  - The buffer drains normally; fetch_pc holds.
- Reset mid-operation: buffer and in-flight word are discarded, and the first read after reset targets RESET_PC.
- IR and IR_PC hold their values while IR_VALID = 0 (don't-care for checking).

Decomposition:
- Package eel_fetch_pkg:
  - fetch_state_t enum {IDLE, RUN}.
  - INSTR_W = 32.
  - struct fetch_entry_t {instr[31:0], pc[31:0]}.
  - Default RESET_PC constant.
- Sub-module fetch_skid_buf: 2-entry FIFO of fetch_entry_t, with push / pop / flush / count / head outputs and synchronous RST.
- The controller holds the FSM, fetch_pc, inflight, and the issue/kill logic.

Test Plan:
- Reset then FETCH_EN = 1, IR_READY = 1, ROM words k at address k -> IMEM_RDEN first high 1 cycle after FETCH_EN; IR_VALID 2 cycles after first issue; IR_PC sequence 0, 4, 8, ... with IR = rom[PC/4], one per cycle.
- Back-pressure: IR_READY = 0 for 10 cycles mid-stream -> count reaches 2, IMEM_RDEN stays 0; on IR_READY = 1 the sequence resumes with no gap or duplicate PC.
- REDIRECT to 32'h0000_0102 while 2 words are buffered and 1 is in flight -> old words never appear; next IR_VALID at t+2 with IR_PC = 32'h100, IR = rom[64], then 32'h104.
- Wrap: REDIRECT to 32'h0000_FFFC -> IR_PC 32'hFFFC then 32'h1_0000 with IR = rom[0] (IMEM_ADDR wraps to 0).
- FETCH_EN = 0 mid-stream -> in-flight word still delivered; no further IMEM_RDEN. Re-enable -> fetch resumes at the next sequential PC.
- RST asserted for 1 cycle during streaming -> next cycle IR_VALID = 0, IMEM_RDEN = 0; after re-enable the first IR_PC = RESET_PC.

Source files
------------

// File: rtl/eel_fetch_pkg.sv
// rtl/eel_fetch_pkg.sv - shared types and constants for the instruction fetch path
//
// Purpose: fetch FSM state encoding, the buffered fetch entry (word + byte PC),
// the instruction width and the default reset PC.
// Ports: none (package).

package eel_fetch_pkg;

  localparam int INSTR_W = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// rtl/fetch_skid_buf.sv - 2-entry FIFO holding fetched words with their PCs
//
// Purpose: in-order buffer between the IMEM read port and decode. Slot 0 is
// always the head, so decode sees registered outputs only.
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   push, din   write an entry at the tail
//   pop         remove the head entry
//   flush       drop all entries (wins over push and pop)
//   count       occupancy 0..2
//   head        head entry; holds its value while empty
//   head_valid  head entry is valid

module fetch_skid_buf
  import eel_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t din,
  input  logic         pop,
  input  logic         flush,
  output logic [1:0]   count,
  output fetch_entry_t head,
  output logic         head_valid
);

  fetch_entry_t slot0;
  fetch_entry_t slot1;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 2'd0;
      slot0 <= '0;
      slot1 <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) slot0 <= din;
          else               slot1 <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          count <= count - 2'd1;
        end
        2'b11: begin
          // Count stays put; the new word lands behind whatever remains.
          if (count == 2'd1) begin
            slot0 <= din;
          end else begin
            slot0 <= slot1;
            slot1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign head       = slot0;
  assign head_valid = (count != 2'd0);

  overflow_check: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && !flush && count == 2'd2));

endmodule

// File: rtl/imem_fetch_ctrl.sv
// rtl/imem_fetch_ctrl.sv - instruction fetch sequencer for the 64 KiB IMEM
//
// Purpose: owns the fetch PC, issues one-word reads to a 1-cycle registered
// IMEM, buffers returned words and hands them to decode over valid/ready.
// A redirect reloads the PC and discards buffered and in-flight words.
// Ports:
//   CLK, RST              clock and synchronous active-high reset
//   FETCH_EN              allow new reads; buffered words drain regardless
//   REDIRECT, REDIRECT_PC load new byte PC (low two bits ignored) and flush
//   IMEM_RDEN, IMEM_ADDR  read request to IMEM (word address)
//   IMEM_DATA             IMEM read data, one cycle after the request
//   IR_VALID, IR_READY    decode handshake
//   IR, IR_PC             head instruction word and its byte PC

module imem_fetch_ctrl
  import eel_fetch_pkg::*;
#(
  parameter int          ADDR_DEPTH = 14,
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  FETCH_EN,
  input  logic                  REDIRECT,
  input  logic [31:0]           REDIRECT_PC,
  output logic                  IMEM_RDEN,
  output logic [ADDR_DEPTH-1:0] IMEM_ADDR,
  input  logic [31:0]           IMEM_DATA,
  output logic                  IR_VALID,
  input  logic                  IR_READY,
  output logic [31:0]           IR,
  output logic [31:0]           IR_PC
);

  fetch_state_t state;
  fetch_state_t state_next;
  logic [31:0]  fetch_pc;
  logic [31:0]  inflight_pc;
  logic [31:0]  redirect_pc_aligned;
  logic [31:0]  issue_pc;
  logic         inflight;
  logic         pop;
  logic         issue;
  logic [1:0]   count;
  logic [2:0]   occupancy;
  fetch_entry_t head;
  fetch_entry_t landing;
  logic         unused_redirect_lsbs;

  assign redirect_pc_aligned  = {REDIRECT_PC[31:2], 2'b00};
  assign unused_redirect_lsbs = ^REDIRECT_PC[1:0];
  assign pop                  = IR_VALID & IR_READY;

  // Slots that will be occupied next cycle if nothing new is issued now;
  // issuing only below 2 is what keeps the buffer from overflowing.
  assign occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (FETCH_EN)  state_next = RUN;
      RUN:  if (!FETCH_EN) state_next = IDLE;
    endcase
  end

  // A redirect issues immediately at the new PC, even from IDLE.
  always_comb begin
    issue    = FETCH_EN & (REDIRECT | ((state == RUN) & (occupancy < 3'd2)));
    issue_pc = REDIRECT ? redirect_pc_aligned : fetch_pc;
  end

  assign IMEM_RDEN = issue;
  assign IMEM_ADDR = issue_pc[ADDR_DEPTH+1:2];

  always_ff @(posedge CLK) begin
    if (RST) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight <= issue;
      if (issue) inflight_pc <= issue_pc;
      if (REDIRECT)   fetch_pc <= FETCH_EN ? redirect_pc_aligned + 32'd4 : redirect_pc_aligned;
      else if (issue) fetch_pc <= fetch_pc + 32'd4;
    end
  end

  // A word returning in the redirect cycle belongs to the old stream: drop it.
  assign landing = '{instr: IMEM_DATA, pc: inflight_pc};

  fetch_skid_buf u_skid (
    .clk        (CLK),
    .rst        (RST),
    .push       (inflight & ~REDIRECT),
    .din        (landing),
    .pop        (pop),
    .flush      (REDIRECT),
    .count      (count),
    .head       (head),
    .head_valid (IR_VALID)
  );

  assign IR    = head.instr;
  assign IR_PC = head.pc;

endmodule
